fetch_queue_unit: RTL and testbench



---
 rtl/fetch_queue_unit.sv | 136 +++++++++++++
 tb/tb_fetch_queue_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: PC generation plus a small {pc, instr} FIFO feeding decode.
// Instruction memory answers combinationally for imem_pc. The FIFO head is
// held in output registers, so decode never sees a combinational path from
// imem_instr.
// Optional macro FETCH_PERF_CNT_EN adds the perf_fetched, perf_stall_full and
// perf_flushes counters.
module fetch_queue_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          fetch_en,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  output logic [31:0]                   imem_pc,
  input  logic [31:0]                   imem_instr,
  output logic                          dec_valid,
  input  logic                          dec_ready,
  output logic [31:0]                   dec_pc,
  output logic [31:0]                   dec_instr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_fetched,
  output logic [31:0]                   perf_stall_full,
  output logic [31:0]                   perf_flushes
`endif
);

  localparam int              AW   = $clog2(FIFO_DEPTH);
  localparam int              CW   = AW + 1;
  localparam logic [CW-1:0]   FULL = CW'(FIFO_DEPTH);
  localparam logic [31:0]     NOP  = 32'h0000_0013;

  logic [31:0]   pc_q;
  logic [AW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic [31:0]   dec_pc_q, dec_instr_q;
  logic [31:0]   pc_mem    [FIFO_DEPTH];
  logic [31:0]   instr_mem [FIFO_DEPTH];

  logic          pop, enq;
  logic [AW-1:0] head_pop;
  logic [CW-1:0] count_pop;
  logic [31:0]   nxt_pc, nxt_instr;

  // Handshake decode: pop needs a valid head; enqueue may reuse the slot a pop frees.
  always_comb begin
    pop       = (count_q != '0) && dec_ready;
    enq       = fetch_en && !redirect_valid && ((count_q != FULL) || pop);
    head_pop  = head_q + AW'(pop);
    count_pop = count_q - CW'(pop);
  end

  // Head value for next cycle: oldest surviving entry, else the entry being
  // written into an empty queue, else hold dec_pc and show NOP.
  always_comb begin
    nxt_pc    = dec_pc_q;
    nxt_instr = NOP;
    if (!redirect_valid) begin
      if (count_pop != '0) begin
        nxt_pc    = pc_mem[head_pop];
        nxt_instr = instr_mem[head_pop];
      end else if (enq) begin
        nxt_pc    = pc_q;
        nxt_instr = imem_instr;
      end
    end
  end

  // Entry storage; contents of empty slots are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      pc_mem[tail_q]    <= pc_q;
      instr_mem[tail_q] <= imem_instr;
    end
  end

  // PC, pointers, occupancy and registered head view.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      dec_pc_q    <= '0;
      dec_instr_q <= NOP;
    end else begin
      dec_pc_q    <= nxt_pc;
      dec_instr_q <= nxt_instr;
      if (redirect_valid) begin
        pc_q    <= {redirect_pc[31:2], 2'b00};
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        head_q  <= head_pop;
        count_q <= count_pop + CW'(enq);
        if (enq) begin
          tail_q <= tail_q + AW'(1);
          pc_q   <= pc_q + 32'd4;
        end
      end
    end
  end

  assign imem_pc    = pc_q;
  assign dec_valid  = (count_q != '0);
  assign dec_pc     = dec_pc_q;
  assign dec_instr  = dec_instr_q;
  assign fifo_count = count_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, stall_q, flush_q;

  // Event counters; free-running and wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_q <= '0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      if (enq) fetched_q <= fetched_q + 32'd1;
      if (fetch_en && !redirect_valid && (count_q == FULL) && !pop)
        stall_q <= stall_q + 32'd1;
      if (redirect_valid) flush_q <= flush_q + 32'd1;
    end
  end

  assign perf_fetched    = fetched_q;
  assign perf_stall_full = stall_q;
  assign perf_flushes    = flush_q;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed scenarios with literal expectations
// plus a long random run against a queue-based reference model.
module tb_fetch_queue_unit;
  localparam int          D    = 4;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] WRST = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset, fetch_en, redirect_valid, dec_ready;
  logic [31:0] redirect_pc;
  logic [31:0] imem_pc, imem_instr, dec_pc, dec_instr;
  logic        dec_valid;
  logic [$clog2(D):0] fifo_count;
  logic [31:0] w_imem_pc, w_imem_instr, w_dec_pc, w_dec_instr;
  logic        w_dec_valid;
  logic [$clog2(D):0] w_fifo_count;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall_full, perf_flushes;
  logic [31:0] w_pf, w_ps, w_pfl;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] fimem(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0001;
  endfunction

  assign imem_instr   = fimem(imem_pc);
  assign w_imem_instr = fimem(w_imem_pc);

  fetch_queue_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_pc(imem_pc), .imem_instr(imem_instr),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_pc(dec_pc), .dec_instr(dec_instr), .fifo_count(fifo_count)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_stall_full(perf_stall_full),
    .perf_flushes(perf_flushes)
`endif
  );

  fetch_queue_unit #(.RESET_PC(WRST), .FIFO_DEPTH(D)) u_wrap (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_pc(w_imem_pc), .imem_instr(w_imem_instr),
    .dec_valid(w_dec_valid), .dec_ready(dec_ready),
    .dec_pc(w_dec_pc), .dec_instr(w_dec_instr), .fifo_count(w_fifo_count)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(w_pf), .perf_stall_full(w_ps), .perf_flushes(w_pfl)
`endif
  );

  // Reference model: a queue of fetched entries, the next PC, and the last
  // displayed dec_pc (held while the queue is empty).
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        mq[$];
  logic [31:0] mpc, mdisp;
  bit          mok = 0;
  logic [31:0] mfetched, mstall, mflush;

  int npass = 0, ntot = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic compare();
    if (!mok) return;
    chk("imem_pc", imem_pc, mpc);
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("dec_valid", 32'(dec_valid), 32'(mq.size() != 0));
    chk("dec_pc", dec_pc, (mq.size() != 0) ? mq[0].pc : mdisp);
    chk("dec_instr", dec_instr, (mq.size() != 0) ? mq[0].instr : NOP);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, mfetched);
    chk("perf_stall_full", perf_stall_full, mstall);
    chk("perf_flushes", perf_flushes, mflush);
`endif
  endtask

  task automatic model_step();
    bit pop, enq;
    if (reset) begin
      mq.delete(); mpc = 32'h0; mdisp = 32'h0; mok = 1;
      mfetched = 0; mstall = 0; mflush = 0;
      return;
    end
    if (!mok) return;
    if (mq.size() != 0) mdisp = mq[0].pc;
    pop = (mq.size() != 0) && dec_ready;
    enq = fetch_en && !redirect_valid && (mq.size() < D || pop);
    if (enq) mfetched++;
    if (fetch_en && !redirect_valid && mq.size() == D && !pop) mstall++;
    if (redirect_valid) begin
      mflush++;
      mq.delete();
      mpc = redirect_pc & ~32'h3;
    end else begin
      if (pop) void'(mq.pop_front());
      if (enq) begin
        mq.push_back('{pc: mpc, instr: fimem(mpc)});
        mpc = mpc + 32'd4;
      end
    end
    if (mq.size() != 0) mdisp = mq[0].pc;
  endtask

  // One clock: drive inputs, check the current state at negedge, advance
  // the model at posedge, return just after the edge.
  task automatic cyc(input bit rst, input bit fe, input bit rv,
                     input logic [31:0] rpc, input bit rdy);
    reset = rst; fetch_en = fe; redirect_valid = rv;
    redirect_pc = rpc; dec_ready = rdy;
    @(negedge clk);
    compare();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    reset = 1; fetch_en = 0; redirect_valid = 0; redirect_pc = 0; dec_ready = 0;

    // Reset state and streaming; the wrap instance checks PC rollover.
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rst imem_pc", imem_pc, 32'h0);
    chk("rst count", 32'(fifo_count), 32'd0);
    chk("rst valid", 32'(dec_valid), 32'd0);
    chk("rst dec_pc", dec_pc, 32'h0);
    chk("rst dec_instr", dec_instr, NOP);
    chk("wrap rst pc", w_imem_pc, WRST);
    cyc(0, 1, 0, 0, 1);
    chk("s1 valid", 32'(dec_valid), 32'd1);
    chk("s1 dec_pc", dec_pc, 32'h0);
    chk("s1 dec_instr", dec_instr, 32'h5A5A_0001);
    chk("s1 imem_pc", imem_pc, 32'h4);
    chk("wrap s1 dec_pc", w_dec_pc, 32'hFFFF_FFF8);
    chk("wrap s1 pc", w_imem_pc, 32'hFFFF_FFFC);
    cyc(0, 1, 0, 0, 1);
    chk("s2 dec_pc", dec_pc, 32'h4);
    chk("wrap s2 dec_pc", w_dec_pc, 32'hFFFF_FFFC);
    chk("wrap s2 pc", w_imem_pc, 32'h0);
    cyc(0, 1, 0, 0, 1);
    chk("wrap s3 dec_pc", w_dec_pc, 32'h0);
    chk("wrap s3 pc", w_imem_pc, 32'h4);
    cyc(0, 1, 0, 0, 1);
    chk("wrap s4 dec_pc", w_dec_pc, 32'h4);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 1);

    // Fill with decode stalled, then pop and enqueue together while full.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, 0, 0);
      chk("fill count", 32'(fifo_count), (i + 1 < D) ? 32'(i + 1) : 32'(D));
    end
    chk("full imem_pc", imem_pc, 32'h10);
    chk("full dec_pc", dec_pc, 32'h0);
    cyc(0, 1, 0, 0, 1);
    chk("full+pop count", 32'(fifo_count), 32'd4);
    chk("full+pop dec_pc", dec_pc, 32'h4);
    chk("full+pop imem_pc", imem_pc, 32'h14);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1);
    chk("drained instr", dec_instr, NOP);
    chk("drained dec_pc", dec_pc, 32'h10);

    // Redirect with three entries buffered.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
    chk("pre-redir count", 32'(fifo_count), 32'd3);
    cyc(0, 1, 1, 32'h0000_1236, 0);
    chk("redir count", 32'(fifo_count), 32'd0);
    chk("redir valid", 32'(dec_valid), 32'd0);
    chk("redir imem_pc", imem_pc, 32'h1234);
    cyc(0, 1, 0, 0, 1);
    chk("post-redir valid", 32'(dec_valid), 32'd1);
    chk("post-redir dec_pc", dec_pc, 32'h1234);

    // Reset wins over redirect with a full queue.
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 1, 32'h800, 1);
    chk("rst-dom count", 32'(fifo_count), 32'd0);
    chk("rst-dom valid", 32'(dec_valid), 32'd0);
    chk("rst-dom imem_pc", imem_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst-dom perf_fetched", perf_fetched, 32'h0);
    chk("rst-dom perf_stall", perf_stall_full, 32'h0);
    chk("rst-dom perf_flushes", perf_flushes, 32'h0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(99) < 1, $urandom_range(99) < 80,
          $urandom_range(99) < 5, $urandom, $urandom_range(99) < 60);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
